// File: rtl/aes_core_rr_arbiter.sv
// Round-robin sequencer sharing one serial AES-128 core among NUM_REQ requesters.
// Optional watchdog: define AES_ARB_TIMEOUT_EN to abort a hung core after TIMEOUT_CYCLES.
module aes_core_rr_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_enc_dec,
   input  logic [NUM_REQ*128-1:0] req_data,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [127:0]           resp_data,
   output logic                   resp_err,
   output logic                   core_start,
   output logic                   core_enc_dec,
   output logic [127:0]           core_data_in,
   output logic [127:0]           core_key_in,
   input  logic [127:0]           core_data_out,
   input  logic                   core_ready,
   output logic                   busy
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] scan_idx;
   logic             grant_any;
   logic             grant;

   // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      grant_any = 1'b0;
      winner    = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!grant_any && req_valid[scan_idx]) begin
            grant_any = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   assign grant     = (state == IDLE) && core_ready && grant_any && !rst;
   assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
   assign busy      = (state != IDLE);

`ifdef AES_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         core_start   <= 1'b0;
         core_enc_dec <= 1'b0;
         core_data_in <= '0;
         core_key_in  <= '0;
         resp_valid   <= '0;
         resp_data    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         resp_err     <= 1'b0;
         tmo_cnt      <= '0;
`endif
      end else begin
         core_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  core_data_in <= req_data[32'(winner)*128 +: 128];
                  core_key_in  <= req_key[32'(winner)*128 +: 128];
                  core_enc_dec <= req_enc_dec[winner];
                  owner        <= winner;
                  rr_ptr       <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                  core_start   <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: state <= WAIT_BUSY;
            WAIT_BUSY: begin
               if (!core_ready)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (core_ready) begin
                  resp_data  <= core_data_out;
                  resp_valid <= NUM_REQ'(1) << owner;
`ifdef AES_ARB_TIMEOUT_EN
                  resp_err   <= 1'b0;
`endif
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[owner]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef AES_ARB_TIMEOUT_EN
         // Placed after the case so an expiring watchdog overrides the normal wait-state update.
         if (state == ISSUE) begin
            tmo_cnt <= '0;
         end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               resp_data  <= '0;
               resp_err   <= 1'b1;
               resp_valid <= NUM_REQ'(1) << owner;
               state      <= RESP;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_aes_core_rr_arbiter.sv
// Directed bench for aes_core_rr_arbiter with a lookup-table core stub.
// Define AES_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_aes_core_rr_arbiter;

   localparam int unsigned N   = 2;
   localparam int unsigned LAT = 8;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_enc_dec = '0;
   logic [N-1:0]     resp_ready = '0;
   logic [N*128-1:0] req_data = '0;
   logic [N*128-1:0] req_key = '0;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     resp_valid;
   logic [127:0]     resp_data;
   logic             resp_err;
   logic             core_start;
   logic             core_enc_dec;
   logic [127:0]     core_data_in;
   logic [127:0]     core_key_in;
   logic [127:0]     core_data_out = '0;
   logic             core_ready = 1'b1;
   logic             busy;

   int checks = 0;
   int errors = 0;

   aes_core_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
      .req_data(req_data), .req_key(req_key),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .core_start(core_start), .core_enc_dec(core_enc_dec), .core_data_in(core_data_in),
      .core_key_in(core_key_in), .core_data_out(core_data_out), .core_ready(core_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Core stub: known FIPS-197 vectors, fixed busy time, optional hang.
   bit           stuck = 1'b0;
   int           busy_cnt = 0;
   logic [127:0] job = '0;
   int           cyc = 0;
   int           start_cnt = 0;
   int           last_start = 0;

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d, input logic e);
      if (e && k == K1 && d == P1) return C1;
      if (e && k == K2 && d == P2) return C2;
      if (e && k == '0 && d == '0) return C0;
      if (!e && k == K1 && d == C1) return P1;
      return ~d ^ k;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_start) begin
         start_cnt  <= start_cnt + 1;
         last_start <= cyc + 1;
      end
      if (core_start && core_ready) begin
         core_ready <= 1'b0;
         busy_cnt   <= LAT;
         job        <= aes_ref(core_key_in, core_data_in, core_enc_dec);
      end else if (!core_ready && !stuck) begin
         if (busy_cnt == 0) begin
            core_ready    <= 1'b1;
            core_data_out <= job;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int unsigned i, input logic [127:0] d, input logic [127:0] k, input logic e);
      req_data[128*i +: 128] = d;
      req_key[128*i +: 128]  = k;
      req_enc_dec[i]         = e;
      req_valid[i]           = 1'b1;
   endtask

   task automatic wait_grant(input string nm, output int unsigned g);
      bit seen;
      seen = 1'b0;
      g    = 0;
      #1;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (|req_ready) seen = 1'b1;
         else @(negedge clk);
      end
      chk({nm, "_grant_seen"}, 128'(seen), 128'(1));
      if (seen) begin
         g = req_ready[1] ? 1 : 0;
         chk({nm, "_grant_onehot"}, 128'($onehot(req_ready)), 128'(1));
      end
      @(posedge clk);
      #1;
      if (seen) req_valid[g] = 1'b0;
   endtask

   task automatic wait_resp(input string nm);
      bit seen;
      seen = 1'b0;
      #1;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (|resp_valid) seen = 1'b1;
         else @(negedge clk);
      end
      chk({nm, "_resp_seen"}, 128'(seen), 128'(1));
   endtask

   task automatic handshake(input string nm);
      resp_ready = resp_valid;
      @(posedge clk);
      #1;
      resp_ready = '0;
      chk({nm, "_resp_cleared"}, 128'(resp_valid), 128'(0));
      chk({nm, "_idle_after"}, 128'(busy), 128'(0));
   endtask

   task automatic run_one(input string nm, input int unsigned exp_g, input logic [127:0] exp_d,
                          input logic exp_enc, input logic [127:0] exp_key);
      int unsigned g;
      int          s0;
      s0 = start_cnt;
      wait_grant(nm, g);
      chk({nm, "_winner"}, 128'(g), 128'(exp_g));
      chk({nm, "_core_enc_dec"}, 128'(core_enc_dec), 128'(exp_enc));
      chk({nm, "_core_key_in"}, core_key_in, exp_key);
      wait_resp(nm);
      chk({nm, "_resp_valid"}, 128'(resp_valid), 128'(N'(1) << exp_g));
      chk({nm, "_resp_data"}, resp_data, exp_d);
      chk({nm, "_resp_err"}, 128'(resp_err), 128'(0));
      chk({nm, "_start_pulses"}, 128'(start_cnt - s0), 128'(1));
      handshake(nm);
   endtask

   typedef struct {
      string        nm;
      logic [1:0]   set_mask;
      logic [127:0] d0, k0, d1, k1;
      logic         e0, e1;
      int unsigned  exp_g;
      logic [127:0] exp_d;
      logic         exp_enc;
      logic [127:0] exp_key;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int unsigned g;
      int          s;
      int          n;
      bit          bad;

      tbl[0] = '{nm:"cont0_a", set_mask:2'b11, d0:P2, k0:K2, d1:'0, k1:'0, e0:1'b1, e1:1'b1,
                 exp_g:0, exp_d:C2, exp_enc:1'b1, exp_key:K2};
      tbl[1] = '{nm:"cont1_a", set_mask:2'b00, d0:'0, k0:'0, d1:'0, k1:'0, e0:1'b0, e1:1'b0,
                 exp_g:1, exp_d:C0, exp_enc:1'b1, exp_key:'0};
      tbl[2] = '{nm:"cont0_b", set_mask:2'b11, d0:P2, k0:K2, d1:'0, k1:'0, e0:1'b1, e1:1'b1,
                 exp_g:0, exp_d:C2, exp_enc:1'b1, exp_key:K2};
      tbl[3] = '{nm:"cont1_b", set_mask:2'b00, d0:'0, k0:'0, d1:'0, k1:'0, e0:1'b0, e1:1'b0,
                 exp_g:1, exp_d:C0, exp_enc:1'b1, exp_key:'0};
      tbl[4] = '{nm:"single_enc", set_mask:2'b01, d0:P1, k0:K1, d1:'0, k1:'0, e0:1'b1, e1:1'b0,
                 exp_g:0, exp_d:C1, exp_enc:1'b1, exp_key:K1};
      tbl[5] = '{nm:"req1_dec", set_mask:2'b10, d0:'0, k0:'0, d1:C1, k1:K1, e0:1'b0, e1:1'b0,
                 exp_g:1, exp_d:P1, exp_enc:1'b0, exp_key:K1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_resp_valid", 128'(resp_valid), 128'(0));
      chk("rst_core_start", 128'(core_start), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_resp_data", resp_data, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].set_mask[0]) set_req(0, tbl[i].d0, tbl[i].k0, tbl[i].e0);
         if (tbl[i].set_mask[1]) set_req(1, tbl[i].d1, tbl[i].k1, tbl[i].e1);
         run_one(tbl[i].nm, tbl[i].exp_g, tbl[i].exp_d, tbl[i].exp_enc, tbl[i].exp_key);
      end

      // Back-pressure: response to req0 held while req1 waits; stray resp_ready[1] ignored.
      set_req(0, P1, K1, 1'b1);
      set_req(1, '0, '0, 1'b1);
      wait_grant("bp", g);
      chk("bp_winner", 128'(g), 128'(0));
      wait_resp("bp");
      s = start_cnt;
      resp_ready = 2'b10;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid !== 2'b01 || resp_data !== C1 || req_ready !== '0 || start_cnt != s) bad = 1'b1;
      end
      resp_ready = '0;
      chk("bp_hold_stable", 128'(bad), 128'(0));
      chk("bp_resp_data", resp_data, C1);
      handshake("bp");
      run_one("bp_next", 1, C0, 1'b1, '0);

      // Reset while the core is busy.
      set_req(0, P2, K2, 1'b1);
      wait_grant("mrst", g);
      n = 0;
      while (core_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_req_ready", 128'(req_ready), 128'(0));
      chk("mrst_resp_valid", 128'(resp_valid), 128'(0));
      chk("mrst_resp_data", resp_data, '0);
      chk("mrst_resp_err", 128'(resp_err), 128'(0));
      chk("mrst_core_start", 128'(core_start), 128'(0));
      chk("mrst_core_enc_dec", 128'(core_enc_dec), 128'(0));
      chk("mrst_core_data_in", core_data_in, '0);
      chk("mrst_core_key_in", core_key_in, '0);
      chk("mrst_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      set_req(1, P1, K1, 1'b1);
      bad = 1'b0;
      n = 0;
      while (!core_ready && n < 100) begin
         @(negedge clk);
         if (!core_ready && req_ready !== '0) bad = 1'b1;
         n++;
      end
      chk("mrst_core_still_busy", 128'(n > 1), 128'(1));
      chk("mrst_no_grant_while_busy", 128'(bad), 128'(0));
      run_one("mrst_next", 1, C1, 1'b1, K1);

`ifdef AES_ARB_TIMEOUT_EN
      stuck = 1'b1;
      set_req(0, P1, K1, 1'b1);
      wait_grant("tmo", g);
      wait_resp("tmo");
      chk("tmo_latency", 128'(cyc - last_start), 128'(16));
      chk("tmo_resp_valid", 128'(resp_valid), 128'(1));
      chk("tmo_resp_err", 128'(resp_err), 128'(1));
      chk("tmo_resp_data", resp_data, '0);
      handshake("tmo");
      set_req(1, P1, K1, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req_ready !== '0) bad = 1'b1;
      end
      chk("tmo_wait_core_ready", 128'(bad), 128'(0));
      stuck = 1'b0;
      run_one("tmo_next", 1, C1, 1'b1, K1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
